// File: rtl/seq_divider.sv
// seq_divider: multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring shift-subtract, one quotient bit per clock. Operands are
// reduced to magnitudes on accept, and the sign is fixed up in FINISH.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt;
  logic             special;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] res_fix;

  // A new request is taken whenever no iteration is running, which includes
  // the done cycle so operations can be issued back to back.
  assign accept   = start && (state != CALC);
  assign a_neg    = ~op[0] & dividend[WIDTH-1];
  assign b_neg    = ~op[0] & divisor[WIDTH-1];
  assign a_mag    = a_neg ? ('0 - dividend) : dividend;
  assign b_mag    = b_neg ? ('0 - divisor) : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = ~op[0] && (dividend == MIN_NEG) && (divisor == '1);

  // The trial remainder is one bit wider than the operands so the compare
  // never overflows; when it fits, the low WIDTH bits of the difference are
  // exact because the true difference is below the divisor.
  assign trial = {rem, quo[WIDTH-1]};
  assign fits  = (trial >= {1'b0, dsr});
  assign diff  = trial[WIDTH-1:0] - dsr;

  // Special cases already hold their final values and bypass sign fix-up.
  assign q_fix   = (special || !neg_q) ? quo : ('0 - quo);
  assign r_fix   = (special || !neg_r) ? rem : ('0 - rem);
  assign res_fix = is_rem ? r_fix : q_fix;

  assign busy   = (state == CALC);
  assign done   = (state == FINISH);
  assign result = (state == FINISH) ? res_fix : result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: specials go straight to FINISH, others iterate WIDTH times.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = (div_zero || ovf) ? FINISH : CALC;
      end
      CALC: begin
        if (cnt == CNT_W'(1)) state_next = FINISH;
      end
      FINISH: begin
        if (accept) state_next = (div_zero || ovf) ? FINISH : CALC;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one shift-subtract step per CALC cycle, and
  // the result register that holds the last answer between done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo      <= '0;
      rem      <= '0;
      dsr      <= '0;
      result_q <= '0;
      cnt      <= '0;
      special  <= 1'b0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      if (state == CALC) begin
        rem <= fits ? diff : trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], fits};
        cnt <= cnt - CNT_W'(1);
      end
      if (state == FINISH) begin
        result_q <= res_fix;
      end
      if (accept) begin
        is_rem <= op[1];
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        dsr    <= b_mag;
        cnt    <= CNT_INIT;
        if (div_zero) begin
          quo     <= '1;
          rem     <= dividend;
          special <= 1'b1;
        end else if (ovf) begin
          quo     <= MIN_NEG;
          rem     <= '0;
          special <= 1'b1;
        end else begin
          quo     <= a_mag;
          rem     <= '0;
          special <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider. The driver pushes the
// expected result and done cycle per accepted request; a negedge monitor pops
// and compares on every done pulse.
module tb_seq_divider;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model written from the RISC-V M-extension rules.
  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == 0) return o[1] ? a : {W{1'b1}};
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    if (o[0]) return o[1] ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return o[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Caller is at a negedge. Drives one start pulse across the next posedge.
  task automatic apply_stimulus(input string name, input logic [1:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] exp, input bit push);
    exp_t e;
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e.res  = exp;
      e.cyc  = cyc + 1 + (is_special(o, a, b) ? 0 : W);
      e.name = name;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits, bounded, for a done pulse; returns at the negedge of the done cycle.
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no done, expected done within 200 cycles", name);
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done with result 0x%08h, expected no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output({e.name, "_result"}, result, e.res);
        check_output({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
        check_output({e.name, "_busy_low"}, 32'(busy), 32'h0);
      end
    end
  end

  initial begin
    logic [1:0]   o;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_done", 32'(done), 32'h0);
    check_output("reset_result", result, 32'h0);

    // Directed cases with hand-derived answers.
    apply_stimulus("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1); wait_done("divu_100_7");
    @(negedge clk);
    apply_stimulus("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1); wait_done("remu_100_7");
    @(negedge clk);
    apply_stimulus("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1); wait_done("divu_max_1");
    @(negedge clk);
    apply_stimulus("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1); wait_done("div_m7_2");
    @(negedge clk);
    apply_stimulus("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1); wait_done("rem_m7_2");
    @(negedge clk);
    apply_stimulus("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1); wait_done("rem_7_m2");
    @(negedge clk);
    apply_stimulus("div_m8_m2", OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 1); wait_done("div_m8_m2");
    @(negedge clk);
    apply_stimulus("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    check_output("div_5_0_busy", 32'(busy), 32'h0);
    wait_done("div_5_0");
    @(negedge clk);
    apply_stimulus("remu_1234_0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1);
    check_output("remu_1234_0_busy", 32'(busy), 32'h0);
    wait_done("remu_1234_0");
    @(negedge clk);
    apply_stimulus("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); wait_done("div_ovf");
    @(negedge clk);
    apply_stimulus("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1); wait_done("rem_ovf");

    // Start while busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    apply_stimulus("divu_1000_7", OP_DIVU, 32'd1000, 32'd7, 32'd142, 1);
    repeat (4) @(negedge clk);
    check_output("busy_mid_calc", 32'(busy), 32'h1);
    apply_stimulus("ignored", OP_DIV, 32'd5, 32'd0, 32'h0, 0);
    wait_done("divu_1000_7");
    apply_stimulus("b2b_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 1);
    wait_done("b2b_divu_9_3");

    // Reset mid-operation discards the in-flight result.
    @(negedge clk);
    apply_stimulus("reset_mid", OP_DIVU, 32'd100, 32'd7, 32'h0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_output("midreset_busy", 32'(busy), 32'h0);
    check_output("midreset_done", 32'(done), 32'h0);
    check_output("midreset_result", result, 32'h0);
    repeat (40) @(negedge clk);

    // Randomized operations against the reference model, some back to back.
    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(0, 3));
      a = rand_val();
      b = rand_val();
      apply_stimulus($sformatf("rand%0d", i), o, a, b, ref_model(o, a, b), 1);
      wait_done($sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle integer divider for the RV32M execute stage; inverse companion to the ripple-carry add/subtract datapath.
- Implements DIV, DIVU, REM and REMU by radix-2 restoring shift-subtract, one quotient bit per clock.
- Sits beside the ALU. The pipeline stalls while busy is high and captures result on done.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).
- CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when busy=0
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0])
- dividend  input  WIDTH  rs1 value, captured on accepted start
- divisor  input  WIDTH  rs2 value, captured on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; result valid in the same cycle
- result  output  WIDTH  quotient or remainder, held until the next done

Behaviour:
- Reset: on a clk edge with rst=1, state=IDLE and busy, done, result, counter and internal registers all clear to 0. Reset overrides everything, including an in-flight operation, whose result is discarded.
- States: IDLE, CALC, FINISH.
- IDLE:
  - Accept start when busy=0. Latch op, sign flags and operand magnitudes (two's-complement negate if op[0]=0 and the MSB is set).
  - Divisor==0 or signed overflow (op[0]=0, dividend=-2^(WIDTH-1), divisor=-1) goes to FINISH.
  - Otherwise goes to CALC with counter=WIDTH.
- CALC, each cycle:
  - rem = {rem[WIDTH-2:0], quo[WIDTH-1]}.
  - quo <<= 1.
  - If rem >= divisor magnitude, subtract it and set quo[0]=1.
  - Compare/subtract is WIDTH+1 bits wide, so there is no overflow.
  - Counter decrements; at counter==1 go to FINISH.
- FINISH, one cycle: update result, pulse done=1, drop busy, return to IDLE.
- Sign correction:
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Unsigned ops take no correction.
- Special cases (RISC-V mandated):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Overflow: quotient = -2^(WIDTH-1); remainder = 0.
- Latency: start accepted at edge k.
  - Normal operation: done at cycle k+WIDTH+1 (33 cycles for WIDTH=32).
  - Special cases: done at k+1.
  - busy is high for cycles k+1 through k+WIDTH for normal operations. For special cases busy never asserts.
- Back-to-back: start may be asserted in the done cycle. busy=0 there, so it is accepted and the new operation begins.
- start while busy=1 is ignored. Operand or op changes during CALC have no effect.
- result changes only in the done cycle and otherwise holds its last value.

Test Plan:
- Reset mid-operation: start DIVU 100/7, assert rst at cycle 10 -> next cycle busy=0, done=0, result=0; no done pulse follows.
- Unsigned: DIVU 100/7 -> done exactly 33 cycles after start, result=14; REMU 100/7 -> result=2; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Signed sign rules: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1; DIV -8/-2 -> 4.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; done at k+1 with busy never high.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; done at k+1.
- Handshake: assert start again at cycle 5 of an operation with different operands -> ignored, original result returned. Then assert start in the done cycle with DIVU 9/3 -> accepted, second done 33 cycles later, result=3.
